// File: rtl/mem_instr_sequencer.sv
// -----------------------------------------------------------------------------
// mem_instr_sequencer
//
// Fetch-and-issue controller for the memory-interface instruction ROM. It
// drives the ROM address/enable pins and decodes each word from the ROM
// (read, shift, wfi, loop). Read and shift words go to the memory datapath
// under a valid/ready handshake. A wfi word blocks until the compute array
// pulses COMPUTE_DONE. The program is replayed NUM_ITER times, then DONE
// pulses for one cycle.
//
// Optional feature (compile-time macro MEM_SEQ_STALL_CNT_EN):
//   adds output STALL_COUNT[31:0], a saturating count of stall cycles.
//   A stall cycle is an offered word that is not accepted, or a cycle spent
//   waiting on a wfi. The count clears on an accepted START.
//
// Ports:
//   CLK, RESET       clock; synchronous active-high reset
//   START, NUM_ITER  begin program from IDLE; iteration count (0 acts as 1)
//   ROM_ADDRESS/ROM_ENABLE/ROM_DATA
//                    ROM interface; the ROM output is registered and only
//                    updates on cycles where ROM_ENABLE is high
//   INSTR_OUT, INSTR_VALID, INSTR_READY, IS_READ, IS_SHIFT, SHIFT_AMT
//                    datapath issue interface
//   COMPUTE_DONE     completion pulse from the compute array
//   PC, ITER_COUNT   address of the current ROM word; completed iterations
//   BUSY, DONE, ILLEGAL
//                    status; ILLEGAL is sticky until START or RESET
// -----------------------------------------------------------------------------
module mem_instr_sequencer #(
  parameter int DATA_WIDTH = 56,
  parameter int ADDR_WIDTH = 6,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [ITER_WIDTH-1:0] NUM_ITER,
  output logic [ADDR_WIDTH-1:0] ROM_ADDRESS,
  output logic                  ROM_ENABLE,
  input  logic [DATA_WIDTH-1:0] ROM_DATA,
  output logic [DATA_WIDTH-1:0] INSTR_OUT,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  output logic                  IS_READ,
  output logic                  IS_SHIFT,
  output logic [3:0]            SHIFT_AMT,
  input  logic                  COMPUTE_DONE,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [ITER_WIDTH-1:0] ITER_COUNT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ILLEGAL
`ifdef MEM_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]           STALL_COUNT
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_ISSUE,
    ST_WAIT_WFI
  } state_t;

  typedef enum logic [2:0] {
    OP_READ,
    OP_SHIFT,
    OP_WFI,
    OP_LOOP,
    OP_ILLEGAL
  } op_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [ITER_WIDTH-1:0] num_iter_q, num_iter_d;
  logic                  pending_q, pending_d;
  logic                  illegal_q, illegal_d;
  logic                  done_q, done_d;
`ifdef MEM_SEQ_STALL_CNT_EN
  logic [31:0]           stall_q, stall_d;
`endif

  op_t                   op;
  logic                  in_issue;
  logic                  start_ok;
  logic                  offer;
  logic                  accept;
  logic                  wfi_go;
  logic                  wait_go;
  logic                  skip;
  logic                  advance;
  logic                  is_loop;
  logic                  last_iter;
  logic                  restart;
  logic                  finish;
  logic [ITER_WIDTH-1:0] iter_inc;
  logic [ITER_WIDTH-1:0] eff_num;

  // Opcode decode of the word currently at the ROM output.
  // NOTE: every variable assigned in an always_comb gets a default first so no
  // path leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    op = OP_ILLEGAL;
    if (ROM_DATA[7:0] == 8'h01)
      op = OP_READ;
    else if (ROM_DATA[7:4] == 4'b0101)
      op = OP_SHIFT;
    else if (ROM_DATA[7:0] == 8'h60)
      op = OP_WFI;
    else if (ROM_DATA[7:0] == 8'h70)
      op = OP_LOOP;
  end

  assign in_issue  = (state_q == ST_ISSUE);
  assign start_ok  = (state_q == ST_IDLE) && START;
  assign offer     = in_issue && ((op == OP_READ) || (op == OP_SHIFT));
  assign accept    = offer && INSTR_READY;
  // A wfi completes immediately if a completion pulse is already banked or
  // arrives in this very cycle.
  assign wfi_go    = in_issue && (op == OP_WFI) && (pending_q || COMPUTE_DONE);
  assign wait_go   = (state_q == ST_WAIT_WFI) && COMPUTE_DONE;
  assign skip      = in_issue && (op == OP_ILLEGAL);
  assign advance   = accept || wfi_go || wait_go || skip;

  // A programmed count of zero runs the program once.
  assign eff_num   = (num_iter_q == '0) ? {{(ITER_WIDTH-1){1'b0}}, 1'b1} : num_iter_q;
  assign iter_inc  = iter_q + 1'b1;
  assign is_loop   = in_issue && (op == OP_LOOP);
  assign last_iter = (iter_inc >= eff_num);
  assign restart   = is_loop && !last_iter;
  assign finish    = is_loop && last_iter;

  // State register.
  // The reset here is synchronous so it matches the rest of this codebase.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      iter_q     <= '0;
      num_iter_q <= '0;
      pending_q  <= 1'b0;
      illegal_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef MEM_SEQ_STALL_CNT_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iter_q     <= iter_d;
      num_iter_q <= num_iter_d;
      pending_q  <= pending_d;
      illegal_q  <= illegal_d;
      done_q     <= done_d;
`ifdef MEM_SEQ_STALL_CNT_EN
      stall_q    <= stall_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iter_d     = iter_q;
    num_iter_d = num_iter_q;
    pending_d  = pending_q;
    illegal_d  = illegal_q;
    done_d     = finish;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d    = ST_PRIME;
          iter_d     = '0;
          num_iter_d = NUM_ITER;
          illegal_d  = 1'b0;
        end
      end
      ST_PRIME: begin
        // Word 0 was fetched on the START edge and is now at the ROM output.
        pc_d    = '0;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (finish)
          state_d = ST_IDLE;
        else if ((op == OP_WFI) && !wfi_go)
          state_d = ST_WAIT_WFI;
      end
      ST_WAIT_WFI: begin
        if (COMPUTE_DONE)
          state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance)
      pc_d = pc_q + 1'b1;  // wraps naturally at 2^ADDR_WIDTH
    else if (restart)
      pc_d = '0;

    if (is_loop)
      iter_d = iter_inc;

    if (skip)
      illegal_d = 1'b1;

    // One-bit completion bank. When a wfi is consumed the bank is spent, but
    // a pulse landing in that cycle while the bank was full is kept.
    if (start_ok)
      pending_d = 1'b0;
    else if (state_q != ST_IDLE) begin
      if (wfi_go || wait_go)
        pending_d = pending_q && COMPUTE_DONE;
      else
        pending_d = pending_q || COMPUTE_DONE;
    end

`ifdef MEM_SEQ_STALL_CNT_EN
    stall_d = stall_q;
    if (start_ok)
      stall_d = '0;
    else if (((offer && !INSTR_READY) || (state_q == ST_WAIT_WFI)) && (stall_q != '1))
      stall_d = stall_q + 1'b1;
`endif
  end

  // Output logic. The ROM is addressed one word ahead of PC and only enabled
  // when the sequence moves on, so a stalled word stays put at the ROM output.
  always_comb begin
    ROM_ADDRESS = pc_q + 1'b1;
    ROM_ENABLE  = 1'b0;
    if (start_ok || restart) begin
      ROM_ADDRESS = '0;
      ROM_ENABLE  = 1'b1;
    end else if (advance) begin
      ROM_ENABLE  = 1'b1;
    end

    INSTR_VALID = offer;
    IS_READ     = offer && (op == OP_READ);
    IS_SHIFT    = offer && (op == OP_SHIFT);
    SHIFT_AMT   = (offer && (op == OP_SHIFT)) ? ROM_DATA[3:0] : 4'd0;
  end

  assign INSTR_OUT  = ROM_DATA;
  assign PC         = pc_q;
  assign ITER_COUNT = iter_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign DONE       = done_q;
  assign ILLEGAL    = illegal_q;
`ifdef MEM_SEQ_STALL_CNT_EN
  assign STALL_COUNT = stall_q;
`endif

endmodule

// File: tb/tb_mem_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_instr_sequencer
//
// Self-checking bench for mem_instr_sequencer. A registered ROM model feeds the
// DUT; expected issued words are derived from the ROM contents and queued when
// a program is started, then popped as the DUT hands words to the datapath.
// All sampling happens on the falling edge inside tick(); inputs change one
// time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_instr_sequencer;

  localparam int DW = 56;
  localparam int AW = 6;
  localparam int IW = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0;
  logic [IW-1:0] NUM_ITER = '0;
  logic [AW-1:0] ROM_ADDRESS;
  logic          ROM_ENABLE;
  logic [DW-1:0] rom_q = '0;
  logic [DW-1:0] INSTR_OUT;
  logic          INSTR_VALID;
  logic          INSTR_READY = 1'b1;
  logic          IS_READ;
  logic          IS_SHIFT;
  logic [3:0]    SHIFT_AMT;
  logic          COMPUTE_DONE = 1'b0;
  logic [AW-1:0] PC;
  logic [IW-1:0] ITER_COUNT;
  logic          BUSY;
  logic          DONE;
  logic          ILLEGAL;
`ifdef MEM_SEQ_STALL_CNT_EN
  logic [31:0]   STALL_COUNT;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] rom_mem [1<<AW];
  bit            auto_en = 1'b0;
  int            cd_cnt = 0;

  mem_instr_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ITER_WIDTH(IW)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .START        (START),
    .NUM_ITER     (NUM_ITER),
    .ROM_ADDRESS  (ROM_ADDRESS),
    .ROM_ENABLE   (ROM_ENABLE),
    .ROM_DATA     (rom_q),
    .INSTR_OUT    (INSTR_OUT),
    .INSTR_VALID  (INSTR_VALID),
    .INSTR_READY  (INSTR_READY),
    .IS_READ      (IS_READ),
    .IS_SHIFT     (IS_SHIFT),
    .SHIFT_AMT    (SHIFT_AMT),
    .COMPUTE_DONE (COMPUTE_DONE),
    .PC           (PC),
    .ITER_COUNT   (ITER_COUNT),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ILLEGAL      (ILLEGAL)
`ifdef MEM_SEQ_STALL_CNT_EN
    ,
    .STALL_COUNT  (STALL_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Registered ROM: output only changes on enabled cycles.
  always @(posedge CLK) begin
    if (ROM_ENABLE)
      rom_q <= rom_mem[ROM_ADDRESS];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [7:0] op);
    logic [47:0] hi;
    hi[31:0]  = $urandom();
    hi[47:32] = 16'($urandom());
    return {hi, op};
  endfunction

  function automatic bit w_read(input logic [DW-1:0] w);
    return w[7:0] == 8'h01;
  endfunction

  function automatic bit w_shift(input logic [DW-1:0] w);
    return w[7:4] == 4'h5;
  endfunction

  // Walk the program as the datapath should see it and queue the issued words.
  task automatic expect_prog(input int n);
    int eff;
    eff = (n == 0) ? 1 : n;
    for (int it = 0; it < eff; it++) begin
      for (int p = 0; p < (1 << AW); p++) begin
        if (w_read(rom_mem[p]) || w_shift(rom_mem[p]))
          sb_q.push_back(rom_mem[p]);
        if (rom_mem[p][7:0] == 8'h70)
          break;
      end
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < (1 << AW); i++)
      rom_mem[i] = mk(8'h70);
  endtask

  // One falling-edge sample: scoreboard compare and optional compute responder.
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge CLK);
    if (INSTR_VALID && INSTR_READY) begin
      check("sb_has_expected", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("instr_out", 64'(INSTR_OUT), 64'(e));
        check("is_read", 64'(IS_READ), 64'(w_read(e)));
        check("is_shift", 64'(IS_SHIFT), 64'(w_shift(e)));
        check("shift_amt", 64'(SHIFT_AMT), w_shift(e) ? 64'(e[3:0]) : 64'd0);
      end
    end
    if (auto_en) begin
      if (cd_cnt == 1) begin
        COMPUTE_DONE = 1'b1;
        cd_cnt = 0;
      end else begin
        COMPUTE_DONE = 1'b0;
        if (cd_cnt > 1)
          cd_cnt--;
        else if (BUSY && !INSTR_VALID && rom_q[7:0] == 8'h60)
          cd_cnt = 5;
      end
    end
  endtask

  task automatic check_reset_vals();
    check("rst_rom_addr", 64'(ROM_ADDRESS), 64'd1);
    check("rst_rom_en", 64'(ROM_ENABLE), 64'd0);
    check("rst_valid", 64'(INSTR_VALID), 64'd0);
    check("rst_is_rd_sh", 64'({IS_READ, IS_SHIFT}), 64'd0);
    check("rst_shamt", 64'(SHIFT_AMT), 64'd0);
    check("rst_pc", 64'(PC), 64'd0);
    check("rst_iter", 64'(ITER_COUNT), 64'd0);
    check("rst_busy_done_ill", 64'({BUSY, DONE, ILLEGAL}), 64'd0);
`ifdef MEM_SEQ_STALL_CNT_EN
    check("rst_stall", 64'(STALL_COUNT), 64'd0);
`endif
  endtask

  // Called just after a falling-edge sample; returns one unit after the START edge.
  task automatic start_prog(input logic [IW-1:0] n);
    @(posedge CLK); #1;
    START = 1'b1;
    NUM_ITER = n;
    tick();
    check("start_rom_en", 64'(ROM_ENABLE), 64'd1);
    check("start_rom_addr", 64'(ROM_ADDRESS), 64'd0);
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input int exp_cyc);
    int cyc;
    bit seen;
    bit prev_busy;
    cyc = 0;
    seen = 1'b0;
    prev_busy = 1'b0;
    while (cyc < budget && !seen) begin
      prev_busy = BUSY;
      tick();
      cyc++;
      if (DONE) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("busy_before_done", 64'(prev_busy), 64'd1);
      check("busy_at_done", 64'(BUSY), 64'd0);
      if (exp_cyc >= 0)
        check("done_cycle", 64'(cyc), 64'(exp_cyc));
      tick();
      check("done_one_cycle", 64'(DONE), 64'd0);
    end
    check("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic wait_wfi(input int budget, output int cyc);
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (cyc < budget && !seen) begin
      tick();
      cyc++;
      if (BUSY && !INSTR_VALID && rom_q[7:0] == 8'h60) seen = 1'b1;
    end
    check("wfi_reached", 64'(seen), 64'd1);
  endtask

  initial begin
    int cyc;
    logic [DW-1:0] held;

    // ---------------- reset values ----------------
    clear_rom();
    tick();
    @(posedge CLK); #1;
    RESET = 1'b0;
    tick();
    check_reset_vals();

    // ---------------- basic program, two iterations ----------------
    clear_rom();
    rom_mem[0] = mk(8'h01);
    rom_mem[1] = mk(8'h5F);
    rom_mem[2] = mk(8'h60);
    rom_mem[3] = mk(8'h70);
    expect_prog(2);
    auto_en = 1'b1;
    cd_cnt = 0;
    start_prog(16'd2);
    run_until_done(100, 20);
    check("iter_after_two", 64'(ITER_COUNT), 64'd2);
    auto_en = 1'b0;
    COMPUTE_DONE = 1'b0;

    // ---------------- backpressure on a shift word ----------------
    clear_rom();
    rom_mem[0] = mk(8'h53);
    rom_mem[1] = mk(8'h01);
    rom_mem[2] = mk(8'h70);
    expect_prog(1);
    @(posedge CLK); #1;
    INSTR_READY = 1'b0;
    start_prog(16'd1);
    cyc = 0;
    while (cyc < 10 && !INSTR_VALID) begin
      tick();
      cyc++;
    end
    check("first_valid_latency", 64'(cyc), 64'd2);
    held = rom_mem[0];
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 64'(INSTR_VALID), 64'd1);
      check("bp_word", 64'(INSTR_OUT), 64'(held));
      check("bp_rom_en", 64'(ROM_ENABLE), 64'd0);
      check("bp_pc", 64'(PC), 64'd0);
      @(posedge CLK); #1;
      if (i == 2) INSTR_READY = 1'b1;
      else tick();
    end
    run_until_done(20, -1);
`ifdef MEM_SEQ_STALL_CNT_EN
    check("stall_count", 64'(STALL_COUNT), 64'd3);
`endif

    // ---------------- completion banked before wfi ----------------
    clear_rom();
    rom_mem[0] = mk(8'h01);
    rom_mem[1] = mk(8'h60);
    rom_mem[2] = mk(8'h01);
    rom_mem[3] = mk(8'h60);
    rom_mem[4] = mk(8'h70);
    expect_prog(1);
    start_prog(16'd1);
    COMPUTE_DONE = 1'b1;
    tick();
    @(posedge CLK); #1;
    COMPUTE_DONE = 1'b0;
    wait_wfi(10, cyc);
    check("wfi_banked_adv", 64'(ROM_ENABLE), 64'd1);
    check("wfi_banked_addr", 64'(ROM_ADDRESS), 64'd2);
    tick();
    check("after_wfi_valid", 64'(INSTR_VALID), 64'd1);
    tick();
    check("wfi2_blocks", 64'({INSTR_VALID, ROM_ENABLE}), 64'd0);
    tick();
    tick();
    tick();
    check("wfi2_waiting", 64'({BUSY, INSTR_VALID, ROM_ENABLE}), 64'b100);
    @(posedge CLK); #1;
    COMPUTE_DONE = 1'b1;
    tick();
    check("wfi2_release", 64'(ROM_ENABLE), 64'd1);
    @(posedge CLK); #1;
    COMPUTE_DONE = 1'b0;
    run_until_done(20, -1);

    // ---------------- NUM_ITER=0, 37-word program ----------------
    clear_rom();
    for (int i = 0; i < 36; i++)
      rom_mem[i] = (i % 3 == 0) ? mk({4'h5, 4'(i)}) : mk(8'h01);
    rom_mem[36] = mk(8'h70);
    expect_prog(0);
    start_prog(16'd0);
    cyc = 0;
    while (cyc < 60 && !(BUSY && rom_q[7:0] == 8'h70)) begin
      tick();
      cyc++;
    end
    check("loop_word_cycle", 64'(cyc), 64'd38);
    check("loop_word_pc", 64'(PC), 64'd36);
    run_until_done(5, 1);
    check("iter_once", 64'(ITER_COUNT), 64'd1);
    tick();
    check("no_second_pass", 64'({BUSY, INSTR_VALID}), 64'd0);

    // ---------------- illegal word skipped, cleared by START ----------------
    clear_rom();
    rom_mem[0] = mk(8'h01);
    rom_mem[1] = mk(8'h00);
    rom_mem[2] = mk(8'h52);
    rom_mem[3] = mk(8'h70);
    expect_prog(1);
    start_prog(16'd1);
    run_until_done(20, 6);
    check("illegal_set", 64'(ILLEGAL), 64'd1);
    expect_prog(1);
    start_prog(16'd1);
    tick();
    check("illegal_cleared", 64'(ILLEGAL), 64'd0);
    run_until_done(20, 5);
    check("illegal_set_again", 64'(ILLEGAL), 64'd1);

    // ---------------- START while busy, then RESET in WAIT_WFI ----------------
    clear_rom();
    rom_mem[0] = mk(8'h00);
    rom_mem[1] = mk(8'h01);
    rom_mem[2] = mk(8'h60);
    rom_mem[3] = mk(8'h70);
    expect_prog(1);
    start_prog(16'd1);
    wait_wfi(10, cyc);
    check("wfi_cycle", 64'(cyc), 64'd4);
    @(posedge CLK); #1;
    START = 1'b1;
    tick();
    check("busy_start_en", 64'({BUSY, ROM_ENABLE, ILLEGAL}), 64'b101);
    @(posedge CLK); #1;
    START = 1'b0;
    RESET = 1'b1;
    tick();
    check("start_ignored", 64'({BUSY, ILLEGAL, PC}), 64'({2'b11, 6'd2}));
`ifdef MEM_SEQ_STALL_CNT_EN
    check("stall_not_cleared", 64'(STALL_COUNT), 64'd1);
`endif
    @(posedge CLK); #1;
    RESET = 1'b0;
    tick();
    check_reset_vals();
    tick();
    check("post_reset_idle", 64'({BUSY, DONE, INSTR_VALID}), 64'd0);
    check("sb_empty_end", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
